// File: rtl/piso_stream.sv
// -----------------------------------------------------------------------------
// piso_stream
//   Parallel-in / serial-out shifter with a valid/ready load handshake.
//   A word of N bits is captured on load && ready and emitted as N/LANES
//   beats of LANES bits, most- or least-significant lane first. A beat is
//   consumed only on cycles with en = 1, so en doubles as a bit-rate strobe.
//   Loading during the last enabled beat reloads without an idle cycle.
//
// Parameters:
//   N          parallel word width (N >= 2)
//   LANES      serial bits per beat (N % LANES == 0)
//   MSB_FIRST  1 = most-significant lane first, 0 = least-significant first
//
// Ports:
//   clk        clock, rising edge
//   rst        synchronous active-high reset
//   d          parallel word, sampled on an accepted load
//   load       producer valid
//   ready      combinational accept indication (no path from load)
//   en         shift enable; current beat is consumed when en = 1
//   out        current serial beat, 0 when out_valid = 0
//   out_valid  a beat is being presented
//   first      out_valid on beat 0
//   last       out_valid on beat BEATS-1
// -----------------------------------------------------------------------------
module piso_stream #(
  parameter int N         = 16,
  parameter int LANES     = 1,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N-1:0]     d,
  input  logic             load,
  output logic             ready,
  input  logic             en,
  output logic [LANES-1:0] out,
  output logic             out_valid,
  output logic             first,
  output logic             last
);

  localparam int BEATS = N / LANES;
  localparam int CW    = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam logic [CW-1:0] LAST_BEAT = CW'(BEATS - 1);

  generate
    if (N < 2 || LANES < 1 || (N % LANES) != 0) begin : g_bad_params
      $error("piso_stream: N must be >= 2 and a multiple of LANES");
    end
  endgenerate

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  state_t           state_reg;
  logic [N-1:0]     shreg_reg;
  logic [CW-1:0]    cnt_reg;

  logic [N-1:0]     shreg_next_beat;
  logic [LANES-1:0] beat;
  logic             at_last;

  assign at_last = (cnt_reg == LAST_BEAT);

  // The presented lane and the shift direction both follow the bit order;
  // vacated positions fill with zero.
  generate
    if (MSB_FIRST) begin : g_msb_first
      assign beat            = shreg_reg[N-1 -: LANES];
      assign shreg_next_beat = shreg_reg << LANES;
    end else begin : g_lsb_first
      assign beat            = shreg_reg[LANES-1:0];
      assign shreg_next_beat = shreg_reg >> LANES;
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= IDLE;
      shreg_reg <= '0;
      cnt_reg   <= '0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (load) begin
            shreg_reg <= d;
            cnt_reg   <= '0;
            state_reg <= SHIFT;
          end
        end
        SHIFT: begin
          // With en low the current beat simply stays presented.
          if (en) begin
            if (!at_last) begin
              shreg_reg <= shreg_next_beat;
              cnt_reg   <= cnt_reg + 1'b1;
            end else if (load) begin
              // Gapless reload: next word's beat 0 follows immediately.
              shreg_reg <= d;
              cnt_reg   <= '0;
            end else begin
              shreg_reg <= '0;
              state_reg <= IDLE;
            end
          end
        end
        default: begin
          state_reg <= IDLE;
          shreg_reg <= '0;
          cnt_reg   <= '0;
        end
      endcase
    end
  end

  // ready depends only on rst, state, cnt and en, never on load, so a
  // producer may derive load from ready without a combinational loop.
  assign ready     = !rst && ((state_reg == IDLE) || (en && at_last));
  assign out_valid = (state_reg == SHIFT);
  assign out       = out_valid ? beat : '0;
  assign first     = out_valid && (cnt_reg == '0);
  assign last      = out_valid && at_last;

endmodule

// File: tb/tb_piso_stream.sv
// -----------------------------------------------------------------------------
// tb_piso_stream
//   Three instances (LANES = 1 MSB first, LANES = 4 LSB first, LANES = 16 LSB
//   first). Accepted words are expanded into their expected beats by plain
//   arithmetic and queued; a monitor per instance compares every cycle with
//   the head of the queue and pops the beat when en consumes it.
// -----------------------------------------------------------------------------
module tb_piso_stream;

  localparam int N = 16;
  localparam int NI = 3;

  typedef struct {
    logic [N-1:0] val;
    bit           f;
    bit           l;
  } beat_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst_s  [NI];
  logic [N-1:0] d_s    [NI];
  logic         load_s [NI];
  logic         en_s   [NI];

  int compared   = 0;
  int mismatched = 0;
  bit started    = 1'b0;

  task automatic check(input string name, input int inst,
                       input logic [N-1:0] act, input logic [N-1:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s inst=%0d t=%0t actual=%h required=%h",
               name, inst, $time, act, exp);
    end
  endtask

  genvar gi;
  generate
    for (gi = 0; gi < NI; gi++) begin : g_inst
      localparam int L  = (gi == 0) ? 1 : ((gi == 1) ? 4 : 16);
      localparam bit MF = (gi == 0);
      localparam int B  = N / L;

      logic [L-1:0] out_w;
      logic [N-1:0] out_ext;
      logic         ready_w, valid_w, first_w, last_w;
      beat_t        q[$];

      always_comb begin
        out_ext        = '0;
        out_ext[L-1:0] = out_w;
      end

      piso_stream #(.N(N), .LANES(L), .MSB_FIRST(MF)) dut (
        .clk      (clk),
        .rst      (rst_s[gi]),
        .d        (d_s[gi]),
        .load     (load_s[gi]),
        .ready    (ready_w),
        .en       (en_s[gi]),
        .out      (out_w),
        .out_valid(valid_w),
        .first    (first_w),
        .last     (last_w)
      );

      // Reference: a word is accepted when no beats are outstanding (the
      // monitor has already popped a last beat consumed this cycle). Its
      // beats are the word cut into L-bit lanes in the chosen order.
      initial begin : model
        logic [N-1:0] w, m;
        beat_t        bt;
        m = {N{1'b1}} >> (N - L);
        forever begin
          @(posedge clk);
          if (rst_s[gi]) begin
            q.delete();
          end else if (load_s[gi] && q.size() == 0) begin
            w = d_s[gi];
            $display("inst %0d lanes %0d accept word %h at t=%0t", gi, L, w, $time);
            for (int b = 0; b < B; b++) begin
              bt.val = MF ? ((w >> (N - L * (b + 1))) & m) : ((w >> (L * b)) & m);
              bt.f   = (b == 0);
              bt.l   = (b == B - 1);
              q.push_back(bt);
            end
          end
        end
      end

      initial begin : monitor
        logic exp_ready;
        forever begin
          @(negedge clk);
          if (started) begin
            exp_ready = !rst_s[gi] && (q.size() == 0 || (q.size() == 1 && en_s[gi]));
            check("ready", gi, N'(ready_w), N'(exp_ready));
            if (q.size() > 0) begin
              check("out_valid", gi, N'(valid_w), N'(1));
              check("out", gi, out_ext, q[0].val);
              check("first", gi, N'(first_w), N'(q[0].f));
              check("last", gi, N'(last_w), N'(q[0].l));
              if (en_s[gi]) void'(q.pop_front());
            end else begin
              check("out_valid", gi, N'(valid_w), N'(0));
              check("out", gi, out_ext, N'(0));
              check("first", gi, N'(first_w), N'(0));
              check("last", gi, N'(last_w), N'(0));
            end
          end
        end
      end
    end
  endgenerate

  task automatic drive(input int i, input bit r, input bit l,
                       input logic [N-1:0] dd, input bit e);
    rst_s[i]  = r;
    load_s[i] = l;
    d_s[i]    = dd;
    en_s[i]   = e;
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    for (int i = 0; i < NI; i++) drive(i, 1'b1, 1'b0, '0, 1'b0);
    repeat (2) @(posedge clk);
    started = 1'b1;
    #1;
    for (int i = 0; i < NI; i++) drive(i, 1'b0, 1'b0, '0, 1'b0);
    tick(1);

    // Single word, MSB first.
    drive(0, 0, 1, 16'h8001, 1); tick(1);
    drive(0, 0, 0, 16'h8001, 1); tick(20);

    // Back-to-back words: A5A5 held until ready, then 0F0F on beat 16.
    drive(0, 0, 1, 16'hA5A5, 1); tick(16);
    drive(0, 0, 1, 16'h0F0F, 1); tick(1);
    drive(0, 0, 0, 16'h0F0F, 1); tick(20);

    // Clock-enable throttling, one enabled cycle in four.
    drive(0, 0, 1, 16'hC003, 0); tick(1);
    for (int c = 0; c < 72; c++) begin
      drive(0, 0, 0, 16'hC003, (c % 4) == 3); tick(1);
    end

    // Reset during beat 5, then a clean word.
    drive(0, 0, 1, 16'hFFFF, 1); tick(1);
    drive(0, 0, 0, 16'hFFFF, 1); tick(4);
    drive(0, 1, 1, 16'hFFFF, 1); tick(1);
    drive(0, 0, 0, 16'hFFFF, 1); tick(1);
    drive(0, 0, 1, 16'h0001, 1); tick(1);
    drive(0, 0, 0, 16'h0001, 1); tick(20);

    // Load toggling while busy; 5555 must wait for the beat-16 ready.
    drive(0, 0, 1, 16'hAAAA, 1); tick(1);
    for (int c = 0; c < 15; c++) begin
      drive(0, 0, (c % 2) == 1, 16'h5555, 1); tick(1);
    end
    drive(0, 0, 1, 16'h5555, 1); tick(1);
    drive(0, 0, 0, 16'h5555, 1); tick(20);

    // Multi-lane LSB first, LANES = 4 and LANES = 16.
    drive(1, 0, 1, 16'h1234, 1); drive(2, 0, 1, 16'h1234, 1); tick(1);
    drive(1, 0, 0, 16'h1234, 1); drive(2, 0, 0, 16'h1234, 1); tick(8);

    // Randomised traffic on all instances with varying enable density.
    for (int c = 0; c < 1500; c++) begin
      for (int i = 0; i < NI; i++) begin
        drive(i, ($urandom % 150) == 0, ($urandom % 3) == 0, N'($urandom),
              ($urandom % (1 + (c / 500))) == 0);
      end
      tick(1);
    end

    for (int i = 0; i < NI; i++) drive(i, 1'b0, 1'b0, '0, 1'b1);
    tick(40);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
